// File: rtl/writeback_arbiter_if.sv
// Writeback bus: ALU and memory producer handshakes plus the register-file write port.
// The slave side is the arbiter; the master side drives producers and rf_stall.
interface writeback_arbiter_if #(
   parameter int LANES  = 8,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int WARP_W = 3
);
   logic                    alu_valid;
   logic                    alu_ready;
   logic [WARP_W-1:0]       alu_warp;
   logic [ADDR_W-1:0]       alu_addr;
   logic [LANES-1:0]        alu_mask;
   logic [LANES*DATA_W-1:0] alu_data;

   logic                    mem_valid;
   logic                    mem_ready;
   logic [WARP_W-1:0]       mem_warp;
   logic [ADDR_W-1:0]       mem_addr;
   logic [LANES-1:0]        mem_mask;
   logic [LANES*DATA_W-1:0] mem_data;

   logic                    rf_stall;
   logic [LANES-1:0]        write_en;
   logic [ADDR_W-1:0]       waddr;
   logic [WARP_W-1:0]       warp_selector;
   logic [LANES*DATA_W-1:0] wdata;
   logic                    busy;

   modport slave (
      input  alu_valid, alu_warp, alu_addr, alu_mask, alu_data,
      output alu_ready,
      input  mem_valid, mem_warp, mem_addr, mem_mask, mem_data,
      output mem_ready,
      input  rf_stall,
      output write_en, waddr, warp_selector, wdata, busy
   );

   modport master (
      output alu_valid, alu_warp, alu_addr, alu_mask, alu_data,
      input  alu_ready,
      output mem_valid, mem_warp, mem_addr, mem_mask, mem_data,
      input  mem_ready,
      output rf_stall,
      input  write_en, waddr, warp_selector, wdata, busy
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs feeding one registered RF write port.
// Define WB_MEM_PRIORITY_EN for fixed memory-over-ALU priority instead of round-robin.
module writeback_arbiter #(
   parameter int LANES      = 8,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 4,
   parameter int WARP_W     = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   writeback_arbiter_if.slave bus
);
   localparam int DATA_BITS = LANES * DATA_W;
   localparam int ENTRY_W   = WARP_W + ADDR_W + LANES + DATA_BITS;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int MASK_LSB  = DATA_BITS;
   localparam int ADDR_LSB  = DATA_BITS + LANES;
   localparam int WARP_LSB  = DATA_BITS + LANES + ADDR_W;

   // Index 0 is the ALU source, index 1 the memory unit.
   logic [1:0]         w_in_valid;
   logic [1:0]         w_ready;
   logic [1:0]         w_push;
   logic [1:0]         w_pop;
   logic [1:0]         w_nonempty;
   logic [1:0]         w_elig;
   logic [ENTRY_W-1:0] w_in_entry [2];
   logic [ENTRY_W-1:0] w_head     [2];
   logic [ENTRY_W-1:0] w_sel;

   logic [LANES-1:0]     r_write_en;
   logic [ADDR_W-1:0]    r_waddr;
   logic [WARP_W-1:0]    r_warp;
   logic [DATA_BITS-1:0] r_wdata;

   assign w_in_valid    = {bus.mem_valid, bus.alu_valid};
   assign w_in_entry[0] = {bus.alu_warp, bus.alu_addr, bus.alu_mask, bus.alu_data};
   assign w_in_entry[1] = {bus.mem_warp, bus.mem_addr, bus.mem_mask, bus.mem_data};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
         logic [PTR_W-1:0]   r_wptr;
         logic [PTR_W-1:0]   r_rptr;
         logic [CNT_W-1:0]   r_count;

         // Ready looks only at the registered count, so a full FIFO refuses even while popping.
         assign w_ready[gi]    = (r_count != CNT_W'(FIFO_DEPTH));
         assign w_push[gi]     = w_in_valid[gi] & w_ready[gi] & (|w_in_entry[gi][MASK_LSB +: LANES]);
         assign w_nonempty[gi] = (r_count != '0);
         assign w_elig[gi]     = w_nonempty[gi] & ~bus.rf_stall;
         assign w_head[gi]     = r_mem[r_rptr];

         always_ff @(posedge clk) begin
            if (w_push[gi]) begin
               r_mem[r_wptr] <= w_in_entry[gi];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_wptr  <= '0;
               r_rptr  <= '0;
               r_count <= '0;
            end else begin
               if (w_push[gi]) r_wptr <= r_wptr + 1'b1;
               if (w_pop[gi])  r_rptr <= r_rptr + 1'b1;
               case ({w_push[gi], w_pop[gi]})
                  2'b10:   r_count <= r_count + 1'b1;
                  2'b01:   r_count <= r_count - 1'b1;
                  default: r_count <= r_count;
               endcase
            end
         end
      end
   endgenerate

`ifdef WB_MEM_PRIORITY_EN
   assign w_pop[1] = w_elig[1];
   assign w_pop[0] = w_elig[0] & ~w_elig[1];
`else
   logic r_last_mem;

   assign w_pop[0] = w_elig[0] & (~w_elig[1] | r_last_mem);
   assign w_pop[1] = w_elig[1] & ~w_pop[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_mem <= 1'b1;
      end else if (|w_pop) begin
         r_last_mem <= w_pop[1];
      end
   end
`endif

   assign w_sel = w_pop[1] ? w_head[1] : w_head[0];

   // Address, warp and data hold between grants; only write_en returns to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write_en <= '0;
         r_waddr    <= '0;
         r_warp     <= '0;
         r_wdata    <= '0;
      end else if (|w_pop) begin
         r_write_en <= w_sel[MASK_LSB +: LANES];
         r_waddr    <= w_sel[ADDR_LSB +: ADDR_W];
         r_warp     <= w_sel[WARP_LSB +: WARP_W];
         r_wdata    <= w_sel[DATA_BITS-1:0];
      end else begin
         r_write_en <= '0;
      end
   end

   assign bus.alu_ready     = w_ready[0];
   assign bus.mem_ready     = w_ready[1];
   assign bus.write_en      = r_write_en;
   assign bus.waddr         = r_waddr;
   assign bus.warp_selector = r_warp;
   assign bus.wdata         = r_wdata;
   assign bus.busy          = (|w_nonempty) | (|r_write_en);
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboarded bench for writeback_arbiter with a small register-file stand-in on the write port.
module tb_writeback_arbiter;
   localparam int LANES      = 8;
   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 4;
   localparam int WARP_W     = 3;
   localparam int FIFO_DEPTH = 4;

   typedef struct {
      logic [LANES-1:0]        mask;
      logic [ADDR_W-1:0]       addr;
      logic [WARP_W-1:0]       warp;
      logic [LANES*DATA_W-1:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_arbiter_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WARP_W(WARP_W)) bus ();

   writeback_arbiter #(
      .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WARP_W(WARP_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   exp_t        exp_q [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [DATA_W-1:0] rf_model [8][16][LANES];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [255:0] mk_data(input logic [31:0] base);
      logic [255:0] d;
      for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = base + 32'(i);
      return d;
   endfunction

   // Register-file stand-in plus scoreboard pop on every issued write.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.write_en != '0) begin
         $display("write warp=%0d addr=%0d mask=%h lane0=%h", bus.warp_selector, bus.waddr,
                  bus.write_en, bus.wdata[DATA_W-1:0]);
         for (int l = 0; l < LANES; l++)
            if (bus.write_en[l]) rf_model[bus.warp_selector][bus.waddr][l] = bus.wdata[l*DATA_W +: DATA_W];
         if (exp_q.size() == 0) begin
            check("unexpected_write", 256'(bus.write_en), 256'(0));
         end else begin
            e = exp_q.pop_front();
            check("wr_mask", 256'(bus.write_en), 256'(e.mask));
            check("wr_addr", 256'(bus.waddr), 256'(e.addr));
            check("wr_warp", 256'(bus.warp_selector), 256'(e.warp));
            check("wr_data", bus.wdata, e.data);
         end
      end
   end

   task automatic send(input bit is_mem, input logic [2:0] warp, input logic [3:0] addr,
                       input logic [7:0] mask, input logic [255:0] data, input bit track);
      bit   ok = 1'b0;
      exp_t e;
      if (is_mem) begin
         bus.mem_valid = 1'b1; bus.mem_warp = warp; bus.mem_addr = addr;
         bus.mem_mask = mask; bus.mem_data = data;
      end else begin
         bus.alu_valid = 1'b1; bus.alu_warp = warp; bus.alu_addr = addr;
         bus.alu_mask = mask; bus.alu_data = data;
      end
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         ok = is_mem ? bus.mem_ready : bus.alu_ready;
      end
      if (!ok) check("send_timeout", 256'(ok), 256'(1));
      @(posedge clk); #1;
      bus.alu_valid = 1'b0;
      bus.mem_valid = 1'b0;
      if (ok && track && mask != 8'h00) begin
         e.mask = mask; e.addr = addr; e.warp = warp; e.data = data;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || bus.busy) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain_in_time", 256'(t < 200), 256'(1));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic push_exp(input logic [2:0] warp, input logic [3:0] addr, input logic [31:0] base);
      exp_t e;
      e.mask = 8'hFF; e.addr = addr; e.warp = warp; e.data = mk_data(base);
      exp_q.push_back(e);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      bus.alu_valid = 1'b0; bus.alu_warp = '0; bus.alu_addr = '0; bus.alu_mask = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b0; bus.mem_warp = '0; bus.mem_addr = '0; bus.mem_mask = '0; bus.mem_data = '0;
      bus.rf_stall  = 1'b0;

      // Reset then idle
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rst_write_en", 256'(bus.write_en), 256'(0));
      check("rst_busy", 256'(bus.busy), 256'(0));
      check("rst_alu_ready", 256'(bus.alu_ready), 256'(1));
      check("rst_mem_ready", 256'(bus.mem_ready), 256'(1));
      check("rst_waddr", 256'(bus.waddr), 256'(0));
      check("rst_warp", 256'(bus.warp_selector), 256'(0));
      check("rst_wdata", bus.wdata, 256'(0));
      @(posedge clk); #1;

      // Single ALU write with latency checks
      send(1'b0, 3'd3, 4'h5, 8'hFF, mk_data(32'hA0), 1'b1);
      @(negedge clk);
      check("single_not_early", 256'(bus.write_en), 256'(0));
      @(negedge clk);
      check("single_we", 256'(bus.write_en), 256'(8'hFF));
      check("single_waddr", 256'(bus.waddr), 256'(5));
      check("single_warp", 256'(bus.warp_selector), 256'(3));
      check("single_wdata2", 256'(bus.wdata[2*DATA_W +: DATA_W]), 256'(32'hA2));
      drain();
      check("rf_read_lane2", 256'(rf_model[3][5][2]), 256'(32'hA2));

      // Partial mask, then zero mask
      send(1'b0, 3'd3, 4'h5, 8'h81, mk_data(32'hB0), 1'b1);
      drain();
      check("partial_lane0", 256'(rf_model[3][5][0]), 256'(32'hB0));
      check("partial_lane3", 256'(rf_model[3][5][3]), 256'(32'hA3));
      check("partial_lane6", 256'(rf_model[3][5][6]), 256'(32'hA6));
      check("partial_lane7", 256'(rf_model[3][5][7]), 256'(32'hB7));
      send(1'b0, 3'd3, 4'h5, 8'h00, mk_data(32'hC0), 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("zero_mask_no_write", 256'(bus.write_en), 256'(0));
         check("zero_mask_idle", 256'(bus.busy), 256'(0));
      end
      check("zero_mask_lane1", 256'(rf_model[3][5][1]), 256'(32'hA1));
      @(posedge clk); #1;

      // Full FIFO and backpressure
      bus.rf_stall = 1'b1;
      for (int k = 0; k < 4; k++)
         send(1'b0, 3'd2, 4'(k), 8'hFF, mk_data(32'hD0 + 32'(k * 16)), 1'b1);
      bus.alu_valid = 1'b1; bus.alu_warp = 3'd2; bus.alu_addr = 4'd4;
      bus.alu_mask = 8'hFF; bus.alu_data = mk_data(32'hE0);
      @(negedge clk);
      check("full_ready_low", 256'(bus.alu_ready), 256'(0));
      @(negedge clk);
      check("held_ready_low", 256'(bus.alu_ready), 256'(0));
      check("stall_no_write", 256'(bus.write_en), 256'(0));
      bus.rf_stall = 1'b0;
      @(negedge clk);
      check("ready_after_pop", 256'(bus.alu_ready), 256'(1));
      @(posedge clk); #1;
      bus.alu_valid = 1'b0;
      push_exp(3'd2, 4'd4, 32'hE0);
      drain();
      check("full_end_ready", 256'(bus.alu_ready), 256'(1));

      // Arbitration order with both FIFOs preloaded
      do_reset();
      bus.rf_stall = 1'b1;
      send(1'b0, 3'd1, 4'd1, 8'hFF, mk_data(32'h100), 1'b0);
      send(1'b0, 3'd1, 4'd2, 8'hFF, mk_data(32'h200), 1'b0);
      send(1'b1, 3'd4, 4'd1, 8'hFF, mk_data(32'h300), 1'b0);
      send(1'b1, 3'd4, 4'd2, 8'hFF, mk_data(32'h400), 1'b0);
`ifdef WB_MEM_PRIORITY_EN
      push_exp(3'd4, 4'd1, 32'h300);
      push_exp(3'd4, 4'd2, 32'h400);
      push_exp(3'd1, 4'd1, 32'h100);
      push_exp(3'd1, 4'd2, 32'h200);
`else
      push_exp(3'd1, 4'd1, 32'h100);
      push_exp(3'd4, 4'd1, 32'h300);
      push_exp(3'd1, 4'd2, 32'h200);
      push_exp(3'd4, 4'd2, 32'h400);
`endif
      bus.rf_stall = 1'b0;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("arb_back_to_back", 256'(bus.write_en), 256'(8'hFF));
      end
      @(negedge clk);
      check("arb_done_idle", 256'(bus.write_en), 256'(0));
      check("arb_all_issued", 256'(exp_q.size()), 256'(0));
      @(posedge clk); #1;

      // Reset in the middle of issuing
      bus.rf_stall = 1'b1;
      for (int k = 0; k < 3; k++)
         send(1'b0, 3'd1, 4'd9, 8'hFF, mk_data(32'h900 + 32'(k)), 1'b0);
      bus.rf_stall = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_we", 256'(bus.write_en), 256'(0));
      check("midrst_busy", 256'(bus.busy), 256'(0));
      check("midrst_alu_ready", 256'(bus.alu_ready), 256'(1));
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_no_write", 256'(bus.write_en), 256'(0));
      end
      check("post_rst_busy", 256'(bus.busy), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of register_block.
- Accepts lane-masked writeback requests from two producers, the ALU and the memory unit, each through a valid/ready handshake.
- Buffers each producer's requests in its own small FIFO.
- Issues at most one register-file write per cycle on register_block's write port: write_en, waddr, wdata_0..7, warp_selector.

Parameters:
- LANES, 8, lanes per warp; width of write_en and lane masks.
- DATA_W, 32, bits per lane.
- ADDR_W, 4, register address width (16 registers).
- WARP_W, 3, warp id width (8 warps).
- FIFO_DEPTH, 4, entries per source FIFO; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU request valid.
- alu_ready  out  1  ALU FIFO can accept.
- alu_warp  in  WARP_W  target warp.
- alu_addr  in  ADDR_W  target register.
- alu_mask  in  LANES  lane write mask.
- alu_data  in  LANES*DATA_W  lane data; lane i is bits [i*DATA_W +: DATA_W].
- mem_valid, mem_ready, mem_warp, mem_addr, mem_mask, mem_data: same as the alu_* ports, for the memory unit.
- rf_stall  in  1  register file cannot take a write this cycle.
- write_en  out  LANES  per-lane write enable to register_block.
- waddr  out  ADDR_W  write address.
- warp_selector  out  WARP_W  write warp.
- wdata  out  LANES*DATA_W  write data; slice i drives register_block wdata_i.
- busy  out  1  any FIFO non-empty or write_en != 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Both FIFOs flushed; any in-flight write is dropped with no partial write.
  - write_en=0, waddr=0, warp_selector=0, wdata=0, busy=0, last_grant=MEM.
  - alu_ready=1 and mem_ready=1, since they are derived from count and count=0.
- Handshake:
  - x_ready = (count_x != FIFO_DEPTH), combinational from registered count only.
  - Push on a rising edge when x_valid & x_ready.
  - A request with mask==0 completes the handshake but is discarded and never enqueued.
  - A full FIFO accepts nothing, even if it pops in the same cycle; there is no pass-through.
- Arbitration, evaluated each cycle using start-of-cycle FIFO state:
  - Eligible = FIFO non-empty and rf_stall==0.
  - Both eligible: grant the source not equal to last_grant (round-robin).
  - One eligible: grant that source.
  - last_grant updates only on a grant.
- Issue:
  - On a grant, pop the head and register it into write_en/waddr/warp_selector/wdata at the next edge.
  - With no grant, write_en is registered to 0; waddr, warp_selector and wdata hold their previous values.
- Latency:
  - Request accepted at edge N: write_en is earliest high after edge N+1, and register_block writes at edge N+2.
  - An entry pushed at edge N is not poppable until the cycle after edge N.
- rf_stall high: no pop, and write_en=0 next cycle. FIFO contents and order are preserved.
- Simultaneous push and pop on the same FIFO: both take effect, count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Ordering: per-source FIFO order is preserved; no ordering is guaranteed between sources.
- Same-target writes: two writes to the same warp/addr are issued in grant order, and the later one wins in the register file.

Optional Feature:
- Macro: WB_MEM_PRIORITY_EN.
- Defined: fixed priority; mem wins whenever both sources are eligible, and last_grant is unused.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 2 cycles, then high.
  - Required: write_en=8'h00, busy=0, alu_ready=mem_ready=1.
- Single ALU write:
  - Stimulus: alu_warp=3, alu_addr=4'h5, alu_mask=8'hFF, lane i data=32'hA0+i.
  - Required: one cycle later write_en=8'hFF, waddr=5, warp_selector=3, wdata_2=32'hA2. A following port-0 read of addr 5, warp 3 returns the same data.
- Round-robin:
  - Stimulus: both FIFOs preloaded with 2 entries while rf_stall=1, then rf_stall=0.
  - Required: issue order ALU0, MEM0, ALU1, MEM1 on 4 consecutive cycles. With WB_MEM_PRIORITY_EN the order is MEM0, MEM1, ALU0, ALU1.
- Full and backpressure:
  - Stimulus: rf_stall=1; push 5 ALU requests.
  - Required: alu_ready falls after the 4th push, and the 5th is held by the producer. Release rf_stall: 4 writes in order, then alu_ready=1.
- Partial mask and zero mask:
  - Stimulus: alu_mask=8'h81, then a request with mask 8'h00.
  - Required: write_en=8'h81, and register_block lanes 1–6 are unchanged. The zero-mask request produces no write cycle.
- Reset mid-operation:
  - Stimulus: 3 entries queued; assert rst_n low asynchronously between edges.
  - Required: write_en=0 immediately, FIFOs empty, and no write is issued after reset release.
